// File: rtl/instr_cache_tag_array_pkg.sv
// Shared configuration for the instruction-cache tag store: default geometry,
// the per-way tag entry layout and the init/flush walk state encoding.
package instr_cache_tag_array_pkg;

  localparam int ICACHE_VADDR_WIDTH = 32;
  localparam int ICACHE_ASSOC       = 4;
  localparam int ICACHE_SETS        = 64;
  localparam int ICACHE_LINE_BYTES  = 64;
  localparam int ICACHE_TAG_W       = ICACHE_VADDR_WIDTH - $clog2(ICACHE_LINE_BYTES)
                                      - $clog2(ICACHE_SETS);

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
  } icache_tag_entry_t;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_FLUSH = 2'd2
  } icache_tag_state_e;

  // Even-parity bit that makes ^{valid, tag, parity} == 0.
  function automatic logic entry_parity(input logic valid, input logic [ICACHE_TAG_W-1:0] tag);
    return ^{valid, tag};
  endfunction

endpackage

// File: rtl/instr_cache_tag_array_rr_victim.sv
// Per-set round-robin victim pointers; combinational read, registered clear/increment.
// Contents are not reset: the init/flush walk clears each set's pointer.
module icache_tag_rr_victim #(
  parameter int SETS  = 64,
  parameter int ASSOC = 4,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(ASSOC)
) (
  input  logic             i_clk,
  input  logic             i_clr_en,
  input  logic [IDX_W-1:0] i_clr_idx,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic             i_inc_en,
  output logic [WAY_W-1:0] o_rd_way
);

  logic [WAY_W-1:0] ptr_q [SETS];

  assign o_rd_way = ptr_q[i_rd_idx];

  // Clear and increment are never requested together (walk vs. ready).
  always_ff @(posedge i_clk) begin
    if (i_clr_en) begin
      ptr_q[i_clr_idx] <= '0;
    end else if (i_inc_en) begin
      ptr_q[i_rd_idx] <= ptr_q[i_rd_idx] + WAY_W'(1);
    end
  end

endmodule

// File: rtl/instr_cache_tag_array.sv
// Set-associative I-cache tag store: 1-cycle registered lookup, round-robin fill, init/flush walk
// that holds o_ready low for SETS cycles. Optional per-entry parity under ICACHE_TAG_PARITY_EN.
module instr_cache_tag_array
  import instr_cache_tag_array_pkg::*;
#(
  parameter int VADDR_WIDTH = ICACHE_VADDR_WIDTH,
  parameter int ASSOC       = ICACHE_ASSOC,
  parameter int SETS        = ICACHE_SETS,
  parameter int LINE_BYTES  = ICACHE_LINE_BYTES,
  localparam int OFS_W = $clog2(LINE_BYTES),
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = VADDR_WIDTH - OFS_W - IDX_W,
  localparam int WAY_W = $clog2(ASSOC)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rd_en,
  input  logic [VADDR_WIDTH-1:0]        i_rd_vaddr,
  output logic                          o_rd_valid,
  output icache_tag_entry_t [ASSOC-1:0] o_rd_tag,
  output logic                          o_rd_hit,
  output logic [WAY_W-1:0]              o_rd_hit_way,
  output logic                          o_rd_parity_err,
  input  logic                          i_fill_en,
  input  logic [VADDR_WIDTH-1:0]        i_fill_vaddr,
  output logic [WAY_W-1:0]              o_fill_way,
  input  logic                          i_flush_req,
  output logic                          o_ready,
  output logic                          o_flush_done
);

  icache_tag_state_e state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              walk_en;
  logic              flush_last;

  logic [IDX_W-1:0] rd_idx, fill_idx;
  logic [TAG_W-1:0] rd_req_tag, fill_tag;
  logic             rd_acc, fill_acc;
  logic [WAY_W-1:0] victim_way;

  logic [TAG_W-1:0] tag_mem [SETS][ASSOC];
  logic [ASSOC-1:0] vld_mem [SETS];

  icache_tag_entry_t [ASSOC-1:0] rd_ent;
  icache_tag_entry_t [ASSOC-1:0] rd_tag_q;
  logic [TAG_W-1:0]              req_tag_q;
  logic                          rd_valid_q;
  logic [WAY_W-1:0]              fill_way_q;
  logic                          flush_done_q;
  logic                          unused_ofs;

  assign rd_idx     = i_rd_vaddr[OFS_W +: IDX_W];
  assign rd_req_tag = i_rd_vaddr[VADDR_WIDTH-1 -: TAG_W];
  assign fill_idx   = i_fill_vaddr[OFS_W +: IDX_W];
  assign fill_tag   = i_fill_vaddr[VADDR_WIDTH-1 -: TAG_W];
  assign unused_ofs = ^{i_rd_vaddr[OFS_W-1:0], i_fill_vaddr[OFS_W-1:0]};

  assign o_ready  = (state_q == S_IDLE);
  assign rd_acc   = o_ready && i_rd_en;
  assign fill_acc = o_ready && i_fill_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush requests seen outside S_IDLE merge into the walk already running.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    walk_en    = 1'b0;
    flush_last = 1'b0;
    case (state_q)
      S_INIT, S_FLUSH: begin
        walk_en = 1'b1;
        cnt_d   = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          flush_last = (state_q == S_FLUSH);
        end
      end
      S_IDLE: begin
        if (i_flush_req) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  icache_tag_rr_victim #(
    .SETS  (SETS),
    .ASSOC (ASSOC)
  ) u_rr_victim (
    .i_clk     (i_clk),
    .i_clr_en  (walk_en),
    .i_clr_idx (cnt_q),
    .i_rd_idx  (fill_idx),
    .i_inc_en  (fill_acc),
    .o_rd_way  (victim_way)
  );

`ifdef ICACHE_TAG_PARITY_EN
  logic             par_mem [SETS][ASSOC];
  logic             rd_perr;
  logic             rd_perr_q;

  always_ff @(posedge i_clk) begin
    if (walk_en) begin
      for (int w = 0; w < ASSOC; w++) begin
        par_mem[cnt_q][w] <= entry_parity(1'b0, tag_mem[cnt_q][w]);
      end
    end else if (fill_acc) begin
      par_mem[fill_idx][victim_way] <= entry_parity(1'b1, fill_tag);
    end
  end

  // A corrupted way is reported invalid so it can never produce a hit.
  always_comb begin
    rd_perr = 1'b0;
    for (int w = 0; w < ASSOC; w++) begin
      rd_ent[w].valid = vld_mem[rd_idx][w];
      rd_ent[w].tag   = tag_mem[rd_idx][w];
      if (^{vld_mem[rd_idx][w], tag_mem[rd_idx][w], par_mem[rd_idx][w]}) begin
        rd_ent[w].valid = 1'b0;
        rd_perr         = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_perr_q <= 1'b0;
    end else if (rd_acc) begin
      rd_perr_q <= rd_perr;
    end
  end

  assign o_rd_parity_err = rd_perr_q;
`else
  always_comb begin
    for (int w = 0; w < ASSOC; w++) begin
      rd_ent[w].valid = vld_mem[rd_idx][w];
      rd_ent[w].tag   = tag_mem[rd_idx][w];
    end
  end

  assign o_rd_parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (walk_en) begin
      vld_mem[cnt_q] <= '0;
    end else if (fill_acc) begin
      tag_mem[fill_idx][victim_way] <= fill_tag;
      vld_mem[fill_idx][victim_way] <= 1'b1;
    end
  end

  // Lookup samples the array before this edge's fill lands (read-before-write).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q   <= 1'b0;
      rd_tag_q     <= '0;
      req_tag_q    <= '0;
      fill_way_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      rd_valid_q   <= rd_acc;
      flush_done_q <= flush_last;
      if (rd_acc) begin
        rd_tag_q  <= rd_ent;
        req_tag_q <= rd_req_tag;
      end
      if (fill_acc) begin
        fill_way_q <= victim_way;
      end
    end
  end

  always_comb begin
    o_rd_hit     = 1'b0;
    o_rd_hit_way = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (rd_tag_q[w].valid && (rd_tag_q[w].tag == req_tag_q)) begin
        o_rd_hit     = 1'b1;
        o_rd_hit_way = WAY_W'(w);
      end
    end
  end

  assign o_rd_valid   = rd_valid_q;
  assign o_rd_tag     = rd_tag_q;
  assign o_fill_way   = fill_way_q;
  assign o_flush_done = flush_done_q;

endmodule
